onehot_req_scheduler: RTL

//  Upstream stage of the 8-to-3 encoder. Captures asynchronous-in-time request pulses into sticky pending bits.

---
 rtl/sched_pkg.sv | 23 ++
 rtl/onehot_pick.sv | 25 ++
 rtl/onehot_req_scheduler.sv | 116 +++++++++++
 3 files changed

// File: rtl/sched_pkg.sv
// Shared definitions for the one-hot request scheduler: source count, index
// width, FSM state encoding and a one-hot to index helper.
package sched_pkg;

   localparam int N     = 8;
   localparam int IDX_W = $clog2(N);

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   // Index of the set bit in a one-hot vector (0 when the vector is empty).
   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (oh[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/onehot_pick.sv
// Combinational masked priority picker. The pending vector is rotated so that
// the start index lands at bit 0, the lowest set bit is isolated, and the
// result is rotated back. Output is one-hot, or zero when nothing is pending.
// With start tied to 0 this is plain fixed priority, lowest index first.
module onehot_pick
   import sched_pkg::*;
(
   input  logic [N-1:0]     pending,
   input  logic [IDX_W-1:0] start,
   output logic [N-1:0]     grant
);

   logic [N-1:0] rot;
   logic [N-1:0] rot_first;

   // Index arithmetic is IDX_W bits wide, so the rotation wraps N-1 -> 0.
   for (genvar gi = 0; gi < N; gi++) begin : g_rot
      assign rot[gi]   = pending[IDX_W'(gi) + start];
      assign grant[gi] = rot_first[IDX_W'(gi) - start];
   end

   // Isolate the lowest set bit of the rotated vector.
   assign rot_first = rot & (~rot + N'(1));

endmodule

// File: rtl/onehot_req_scheduler.sv
// One-hot request scheduler: captures request pulses into sticky pending
// bits and offers them one at a time as a strictly one-hot grant with a
// valid/ready handshake. A grant is held stable until accepted, and every
// handshake is followed by one IDLE bubble cycle.
// Build option: define ROUND_ROBIN_EN for rotating priority; otherwise
// fixed priority with bit 0 highest.
module onehot_req_scheduler
   import sched_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [N-1:0] onehot_o,
   output logic [N-1:0] pending_o,
   output logic [N-1:0] overflow_o
);

   state_t           state_reg, state_next;
   logic [N-1:0]     pending_reg, pending_next;
   logic [N-1:0]     overflow_reg, overflow_next;
   logic [N-1:0]     onehot_reg, onehot_next;
   logic             valid_reg, valid_next;
   logic [N-1:0]     served;
   logic [N-1:0]     pick;
   logic [IDX_W-1:0] pick_start;
   logic             handshake;

`ifdef ROUND_ROBIN_EN
   logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;

   assign pick_start = rr_ptr_reg;

   // Next search start is just past the source served on each handshake.
   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (handshake) rr_ptr_next = onehot_to_idx(onehot_reg) + IDX_W'(1);
   end

   // Round-robin pointer register.
   always_ff @(posedge clk) begin
      if (rst) rr_ptr_reg <= '0;
      else     rr_ptr_reg <= rr_ptr_next;
   end
`else
   assign pick_start = '0;
`endif

   onehot_pick u_pick (
      .pending (pending_reg),
      .start   (pick_start),
      .grant   (pick)
   );

   assign handshake = valid_reg && ready_i;
   assign served    = handshake ? onehot_reg : '0;

   // Pending/overflow bookkeeping: a same-cycle request re-arms the served bit
   // and is not counted as an overflow.
   always_comb begin
      pending_next  = (pending_reg & ~served) | req_i;
      overflow_next = overflow_reg | (req_i & pending_reg & ~served);
   end

   // Grant FSM: pick from pending in IDLE, hold the offer until accepted.
   always_comb begin
      state_next  = state_reg;
      onehot_next = onehot_reg;
      valid_next  = valid_reg;
      case (state_reg)
         IDLE: begin
            if (pending_reg != '0) begin
               onehot_next = pick;
               valid_next  = 1'b1;
               state_next  = OFFER;
            end
         end
         OFFER: begin
            if (ready_i) begin
               onehot_next = '0;
               valid_next  = 1'b0;
               state_next  = IDLE;
            end
         end
         default: begin
            onehot_next = '0;
            valid_next  = 1'b0;
            state_next  = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any offer without a handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         pending_reg  <= '0;
         overflow_reg <= '0;
         onehot_reg   <= '0;
         valid_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         pending_reg  <= pending_next;
         overflow_reg <= overflow_next;
         onehot_reg   <= onehot_next;
         valid_reg    <= valid_next;
      end
   end

   assign valid_o    = valid_reg;
   assign onehot_o   = onehot_reg;
   assign pending_o  = pending_reg;
   assign overflow_o = overflow_reg;

endmodule
